// File: rtl/mem_controller.sv
// Shares NUM_CHANNELS data-memory ports among NUM_CONSUMERS load-store units.
// Requests are granted round-robin and each channel runs its own request/wait/relay FSM.
module mem_controller #(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CONSUMERS-1:0]                    consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                    consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                    consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                    consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                     mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                     mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      mem_read_data,
    output logic [NUM_CHANNELS-1:0]                     mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                     mem_write_ready
);
    localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_READ_WAITING   = 3'd1;
    localparam logic [2:0] ST_WRITE_WAITING  = 3'd2;
    localparam logic [2:0] ST_READ_RELAYING  = 3'd3;
    localparam logic [2:0] ST_WRITE_RELAYING = 3'd4;

    logic [NUM_CHANNELS-1:0][2:0]                   r_state,  w_state_nxt;
    logic [NUM_CHANNELS-1:0][IW-1:0]                r_idx,    w_idx_nxt;
    logic [NUM_CONSUMERS-1:0]                       r_claim,  w_claim_nxt;
    logic [IW-1:0]                                  r_rr_ptr, w_rr_ptr_nxt;
    logic [NUM_CHANNELS-1:0]                        w_grant;
    logic [NUM_CHANNELS-1:0]                        w_grant_rd;
    logic [NUM_CHANNELS-1:0][IW-1:0]                w_grant_idx;

    logic [NUM_CONSUMERS-1:0]                       r_consumer_read_ready,  w_consumer_read_ready_nxt;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]        r_consumer_read_data,   w_consumer_read_data_nxt;
    logic [NUM_CONSUMERS-1:0]                       r_consumer_write_ready, w_consumer_write_ready_nxt;
    logic [NUM_CHANNELS-1:0]                        r_mem_read_valid,       w_mem_read_valid_nxt;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]         r_mem_read_address,     w_mem_read_address_nxt;
    logic [NUM_CHANNELS-1:0]                        r_mem_write_valid,      w_mem_write_valid_nxt;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]         r_mem_write_address,    w_mem_write_address_nxt;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]         r_mem_write_data,       w_mem_write_data_nxt;

    // Round-robin arbitration across idle channels and per-channel next state
    always_comb begin
        logic [NUM_CONSUMERS-1:0] v_taken;
        logic                     v_found;
        logic                     v_hit;
        int                       v_cand;
        int                       v_pick;
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_claim_nxt  = r_claim;
        w_rr_ptr_nxt = r_rr_ptr;
        w_grant      = '0;
        w_grant_rd   = '0;
        w_grant_idx  = '0;
        v_taken      = r_claim;
        v_found      = 1'b0;
        v_hit        = 1'b0;
        v_cand       = 0;
        v_pick       = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (r_state[c])
                ST_IDLE: begin
                    v_found = 1'b0;
                    v_pick  = 0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        v_cand  = (int'(r_rr_ptr) + k) % NUM_CONSUMERS;
                        v_hit   = !v_found && !v_taken[v_cand] &&
                                  (consumer_read_valid[v_cand] || consumer_write_valid[v_cand]);
                        v_pick  = v_hit ? v_cand : v_pick;
                        v_found = v_found | v_hit;
                    end
                    if (v_found) begin
                        v_taken[v_pick]     = 1'b1;
                        w_claim_nxt[v_pick] = 1'b1;
                        w_grant[c]          = 1'b1;
                        w_grant_idx[c]      = IW'(v_pick);
                        w_grant_rd[c]       = consumer_read_valid[v_pick];
                        w_idx_nxt[c]        = IW'(v_pick);
                        w_state_nxt[c]      = consumer_read_valid[v_pick] ? ST_READ_WAITING
                                                                          : ST_WRITE_WAITING;
                        w_rr_ptr_nxt        = IW'((v_pick + 1) % NUM_CONSUMERS);
                    end else begin
                        w_state_nxt[c] = ST_IDLE;
                    end
                end
                ST_READ_WAITING: begin
                    w_state_nxt[c] = mem_read_ready[c] ? ST_READ_RELAYING : ST_READ_WAITING;
                end
                ST_WRITE_WAITING: begin
                    w_state_nxt[c] = mem_write_ready[c] ? ST_WRITE_RELAYING : ST_WRITE_WAITING;
                end
                ST_READ_RELAYING: begin
                    if (!consumer_read_valid[r_idx[c]]) begin
                        w_state_nxt[c]         = ST_IDLE;
                        w_claim_nxt[r_idx[c]]  = 1'b0;
                    end else begin
                        w_state_nxt[c] = ST_READ_RELAYING;
                    end
                end
                ST_WRITE_RELAYING: begin
                    if (!consumer_write_valid[r_idx[c]]) begin
                        w_state_nxt[c]         = ST_IDLE;
                        w_claim_nxt[r_idx[c]]  = 1'b0;
                    end else begin
                        w_state_nxt[c] = ST_WRITE_RELAYING;
                    end
                end
                default: begin
                    w_state_nxt[c] = ST_IDLE;
                end
            endcase
        end
    end

    // Next values of the registered memory-side and consumer-side outputs
    always_comb begin
        w_consumer_read_ready_nxt  = r_consumer_read_ready;
        w_consumer_read_data_nxt   = r_consumer_read_data;
        w_consumer_write_ready_nxt = r_consumer_write_ready;
        w_mem_read_valid_nxt       = r_mem_read_valid;
        w_mem_read_address_nxt     = r_mem_read_address;
        w_mem_write_valid_nxt      = r_mem_write_valid;
        w_mem_write_address_nxt    = r_mem_write_address;
        w_mem_write_data_nxt       = r_mem_write_data;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (r_state[c])
                ST_IDLE: begin
                    if (w_grant[c] && w_grant_rd[c]) begin
                        w_mem_read_valid_nxt[c]    = 1'b1;
                        w_mem_read_address_nxt[c]  = consumer_read_address[w_grant_idx[c]];
                    end else if (w_grant[c]) begin
                        w_mem_write_valid_nxt[c]   = 1'b1;
                        w_mem_write_address_nxt[c] = consumer_write_address[w_grant_idx[c]];
                        w_mem_write_data_nxt[c]    = consumer_write_data[w_grant_idx[c]];
                    end else begin
                        w_mem_read_valid_nxt[c]    = 1'b0;
                        w_mem_write_valid_nxt[c]   = 1'b0;
                    end
                end
                ST_READ_WAITING: begin
                    if (mem_read_ready[c]) begin
                        w_mem_read_valid_nxt[c]             = 1'b0;
                        w_consumer_read_ready_nxt[r_idx[c]] = 1'b1;
                        w_consumer_read_data_nxt[r_idx[c]]  = mem_read_data[c];
                    end else begin
                        w_mem_read_valid_nxt[c] = 1'b1;
                    end
                end
                ST_WRITE_WAITING: begin
                    if (mem_write_ready[c]) begin
                        w_mem_write_valid_nxt[c]             = 1'b0;
                        w_consumer_write_ready_nxt[r_idx[c]] = 1'b1;
                    end else begin
                        w_mem_write_valid_nxt[c] = 1'b1;
                    end
                end
                // Ready stays up exactly as long as the consumer keeps its valid asserted
                ST_READ_RELAYING: begin
                    w_consumer_read_ready_nxt[r_idx[c]]  = consumer_read_valid[r_idx[c]];
                end
                ST_WRITE_RELAYING: begin
                    w_consumer_write_ready_nxt[r_idx[c]] = consumer_write_valid[r_idx[c]];
                end
                default: begin
                    w_mem_read_valid_nxt[c]  = 1'b0;
                    w_mem_write_valid_nxt[c] = 1'b0;
                end
            endcase
        end
    end

    // State, arbitration and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state                <= '0;
            r_idx                  <= '0;
            r_claim                <= '0;
            r_rr_ptr               <= '0;
            r_consumer_read_ready  <= '0;
            r_consumer_read_data   <= '0;
            r_consumer_write_ready <= '0;
            r_mem_read_valid       <= '0;
            r_mem_read_address     <= '0;
            r_mem_write_valid      <= '0;
            r_mem_write_address    <= '0;
            r_mem_write_data       <= '0;
        end else begin
            r_state                <= w_state_nxt;
            r_idx                  <= w_idx_nxt;
            r_claim                <= w_claim_nxt;
            r_rr_ptr               <= w_rr_ptr_nxt;
            r_consumer_read_ready  <= w_consumer_read_ready_nxt;
            r_consumer_read_data   <= w_consumer_read_data_nxt;
            r_consumer_write_ready <= w_consumer_write_ready_nxt;
            r_mem_read_valid       <= w_mem_read_valid_nxt;
            r_mem_read_address     <= w_mem_read_address_nxt;
            r_mem_write_valid      <= w_mem_write_valid_nxt;
            r_mem_write_address    <= w_mem_write_address_nxt;
            r_mem_write_data       <= w_mem_write_data_nxt;
        end
    end

    assign consumer_read_ready  = r_consumer_read_ready;
    assign consumer_read_data   = r_consumer_read_data;
    assign consumer_write_ready = r_consumer_write_ready;
    assign mem_read_valid       = r_mem_read_valid;
    assign mem_read_address     = r_mem_read_address;
    assign mem_write_valid      = r_mem_write_valid;
    assign mem_write_address    = r_mem_write_address;
    assign mem_write_data       = r_mem_write_data;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: a one-channel and a two-channel instance share the LSU inputs.
// Memory responders and a registered-LSU model live in the tick task.
module tb_mem_controller;
    logic clk;
    logic reset;

    logic [7:0]        rv, wv;
    logic [7:0][7:0]   ra, wa;
    logic [7:0][15:0]  wd;

    logic [7:0]        a_crr, a_cwr;
    logic [7:0][15:0]  a_crd;
    logic [0:0]        a_mrv, a_mrr, a_mwv, a_mwr, a_en, a_force;
    logic [0:0][7:0]   a_mra, a_mwa;
    logic [0:0][15:0]  a_mrd, a_mwd;

    logic [7:0]        b_crr, b_cwr;
    logic [7:0][15:0]  b_crd;
    logic [1:0]        b_mrv, b_mrr, b_mwv, b_mwr, b_en;
    logic [1:0][7:0]   b_mra, b_mwa;
    logic [1:0][15:0]  b_mrd, b_mwd;

    logic              sel2;
    int                order_q[$];
    int                tests_run;
    int                tests_failed;

    mem_controller #(.NUM_CONSUMERS(8), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(16)) u_dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
        .consumer_write_valid(wv), .consumer_write_address(wa),
        .consumer_write_data(wd), .consumer_write_ready(a_cwr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
    );

    mem_controller #(.NUM_CONSUMERS(8), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(16)) u_dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
        .consumer_write_valid(wv), .consumer_write_address(wa),
        .consumer_write_data(wd), .consumer_write_ready(b_cwr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: memories answer on the falling edge, LSUs drop valid the edge after seeing ready
    task automatic tick();
        logic [7:0] seen_r;
        logic [7:0] seen_w;
        logic [7:0] new_r;
        @(negedge clk);
        a_mrr  = (a_mrv & a_en) | a_force;
        a_mwr  = a_mwv & a_en;
        b_mrr  = b_mrv & b_en;
        b_mwr  = b_mwv & b_en;
        seen_r = sel2 ? b_crr : a_crr;
        seen_w = sel2 ? b_cwr : a_cwr;
        @(posedge clk);
        #1;
        rv    = rv & ~seen_r;
        wv    = wv & ~seen_w;
        new_r = (sel2 ? b_crr : a_crr) & ~seen_r;
        for (int i = 0; i < 8; i++) begin
            if (new_r[i]) order_q.push_back(i);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rv    = 8'd0;
        wv    = 8'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic int pack_order();
        int v;
        v = 0;
        foreach (order_q[i]) v = v * 16 + order_q[i];
        return v;
    endfunction

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({a_mrv, a_mwv, a_crr, a_cwr} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_ctl1: got %h expected 0", {a_mrv, a_mwv, a_crr, a_cwr});
        end
        tests_run++;
        if ({a_mra, a_mwa, a_mwd, a_crd} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data1: nonzero address/data after reset");
        end
        tests_run++;
        if ({b_mrv, b_mwv, b_crr, b_cwr, b_mra, b_mwa, b_mwd, b_crd} !== '0) begin
            tests_failed++;
            $display("FAIL reset_dut2: nonzero output after reset");
        end
    endtask

    task automatic test_read();
        int cnt;
        int first;
        sel2  = 1'b0;
        a_en  = 1'b1;
        a_mrd = 16'hBEEF;
        ra[0] = 8'h10;
        rv    = 8'b0000_0001;
        tick();
        tests_run++;
        if (a_mrv !== 1'b1 || a_mra[0] !== 8'h10 || a_mwv !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_req: valid=%b addr=%h wvalid=%b expected 1 10 0", a_mrv, a_mra[0], a_mwv);
        end
        cnt   = 0;
        first = -1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (a_crr[0]) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        tests_run++;
        if (cnt !== 2) begin
            tests_failed++;
            $display("FAIL read_ready_len: got %0d cycles expected 2", cnt);
        end
        tests_run++;
        if (first !== 0) begin
            tests_failed++;
            $display("FAIL read_latency: ready first at %0d expected 0", first);
        end
        tests_run++;
        if (a_crd[0] !== 16'hBEEF || a_crr !== 8'd0 || a_mrv !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_data: data=%h ready=%h mvalid=%b expected beef 00 0", a_crd[0], a_crr, a_mrv);
        end
    endtask

    task automatic test_write();
        int wcnt;
        int rcnt;
        int mcnt;
        sel2  = 1'b0;
        a_en  = 1'b1;
        wa[3] = 8'h2A;
        wd[3] = 16'h1234;
        wv    = 8'b0000_1000;
        tick();
        tests_run++;
        if (a_mwv !== 1'b1 || a_mwa[0] !== 8'h2A || a_mwd[0] !== 16'h1234) begin
            tests_failed++;
            $display("FAIL write_req: valid=%b addr=%h data=%h expected 1 2a 1234", a_mwv, a_mwa[0], a_mwd[0]);
        end
        mcnt = 1;
        wcnt = 0;
        rcnt = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (a_mwv) mcnt++;
            if (a_cwr[3]) wcnt++;
            if (a_mrv || (a_crr != 8'd0)) rcnt++;
        end
        tests_run++;
        if (mcnt !== 1 || wcnt !== 2) begin
            tests_failed++;
            $display("FAIL write_burst: mem cycles=%0d ack cycles=%0d expected 1 2", mcnt, wcnt);
        end
        tests_run++;
        if (rcnt !== 0 || a_cwr !== 8'd0) begin
            tests_failed++;
            $display("FAIL write_no_read: read activity=%0d ack=%h expected 0 00", rcnt, a_cwr);
        end
    endtask

    task automatic test_fairness();
        logic rearmed;
        do_reset();
        sel2    = 1'b0;
        a_en    = 1'b1;
        a_mrd   = 16'h0F0F;
        ra[0]   = 8'h00;
        ra[2]   = 8'h02;
        ra[5]   = 8'h05;
        rearmed = 1'b0;
        order_q.delete();
        rv      = 8'b0010_0101;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (!rearmed && rv[0] == 1'b0 && a_crr[0] == 1'b0 && order_q.size() >= 1) begin
                rv[0]   = 1'b1;
                rearmed = 1'b1;
            end
            if (rearmed && rv == 8'd0 && a_crr == 8'd0) break;
        end
        tests_run++;
        if (order_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL fair_count: got %0d services expected 4", order_q.size());
        end
        tests_run++;
        if (pack_order() !== 32'h0250) begin
            tests_failed++;
            $display("FAIL fair_order: got %h expected 0250 (0,2,5,0)", pack_order());
        end
    endtask

    task automatic test_two_channels();
        do_reset();
        sel2     = 1'b1;
        a_en     = 1'b1;
        b_en     = 2'b10;
        b_mrd[0] = 16'h1111;
        b_mrd[1] = 16'h4444;
        ra[1]    = 8'h41;
        ra[4]    = 8'h44;
        order_q.delete();
        rv       = 8'b0001_0010;
        tick();
        tests_run++;
        if (b_mrv !== 2'b11 || b_mra[0] !== 8'h41 || b_mra[1] !== 8'h44 || b_mwv !== 2'b00) begin
            tests_failed++;
            $display("FAIL dual_grant: valid=%b a0=%h a1=%h expected 11 41 44", b_mrv, b_mra[0], b_mra[1]);
        end
        tick();
        tests_run++;
        if (b_crr !== 8'b0001_0000 || b_crd[4] !== 16'h4444 || b_mrv !== 2'b01) begin
            tests_failed++;
            $display("FAIL dual_ch1_first: ready=%h data=%h valid=%b expected 10 4444 01", b_crr, b_crd[4], b_mrv);
        end
        b_en = 2'b11;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (rv == 8'd0 && b_crr == 8'd0) break;
        end
        tests_run++;
        if (pack_order() !== 32'h41 || b_crd[1] !== 16'h1111) begin
            tests_failed++;
            $display("FAIL dual_order: order=%h data1=%h expected 41 1111", pack_order(), b_crd[1]);
        end
        sel2 = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        sel2  = 1'b0;
        a_en  = 1'b0;
        ra[2] = 8'h33;
        rv    = 8'b0000_0100;
        tick();
        tests_run++;
        if (a_mrv !== 1'b1 || a_mra[0] !== 8'h33) begin
            tests_failed++;
            $display("FAIL midreset_pre: valid=%b addr=%h expected 1 33", a_mrv, a_mra[0]);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if ({a_mrv, a_mwv, a_crr, a_cwr} !== 18'd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got %h expected 0", {a_mrv, a_mwv, a_crr, a_cwr});
        end
        reset = 1'b0;
        a_en  = 1'b1;
        a_mrd = 16'h5A5A;
        order_q.delete();
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rv == 8'd0 && a_crr == 8'd0) break;
        end
        tests_run++;
        if (pack_order() !== 32'h2 || order_q.size() !== 1 || a_crd[2] !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL midreset_after: order=%h n=%0d data=%h expected 2 1 5a5a",
                     pack_order(), order_q.size(), a_crd[2]);
        end
    endtask

    task automatic test_spurious_ready();
        sel2    = 1'b0;
        a_force = 1'b1;
        a_mrd   = 16'hDEAD;
        tick();
        tick();
        tick();
        a_force = 1'b0;
        tests_run++;
        if (a_crr !== 8'd0 || a_mrv !== 1'b0 || a_cwr !== 8'd0 || a_mwv !== 1'b0) begin
            tests_failed++;
            $display("FAIL spurious_ctl: ready=%h mvalid=%b expected 00 0", a_crr, a_mrv);
        end
        tests_run++;
        if (a_crd[2] !== 16'h5A5A || a_crd[0] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL spurious_data: d2=%h d0=%h expected 5a5a 0000", a_crd[2], a_crd[0]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        rv           = 8'd0;
        wv           = 8'd0;
        ra           = '0;
        wa           = '0;
        wd           = '0;
        a_en         = 1'b1;
        a_force      = 1'b0;
        b_en         = 2'b11;
        a_mrr        = 1'b0;
        a_mwr        = 1'b0;
        b_mrr        = 2'b00;
        b_mwr        = 2'b00;
        a_mrd        = '0;
        b_mrd        = '0;
        sel2         = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_fairness();
        test_two_channels();
        test_reset_mid_read();
        test_spurious_ready();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
